// File: rtl/mvm_pkg.sv
// mvm_pkg: shared definitions for the matrix-vector multiply datapath.
//   - default core dimensions (MVM_K, MVM_B) shared by the feeder and the core
//   - host command opcode encoding (mvm_op_e)
//   - state encoding of the load sequencer (seq_state_e)
package mvm_pkg;

    localparam int MVM_K = 8;
    localparam int MVM_B = 12;

    typedef enum logic [1:0] {
        MVM_OP_LOAD_MAT = 2'd0,
        MVM_OP_LOAD_VEC = 2'd1,
        MVM_OP_START    = 2'd2,
        MVM_OP_RSVD     = 2'd3
    } mvm_op_e;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_FILL,
        SEQ_CMD,
        SEQ_LEADWAIT,
        SEQ_BURST,
        SEQ_RUN,
        SEQ_DRAIN
    } seq_state_e;

endpackage

// File: rtl/mvm_burst_buffer.sv
// mvm_burst_buffer: DEPTH x B word store feeding the core burst.
//   clk, reset        : clock; reset clears only the read register, never the array
//   we, wr_ptr, wr_data : write port
//   re, rd_ptr        : read request; the word appears on rd_data next cycle
//   rd_data           : registered read data, 0 in any cycle following no request
module mvm_burst_buffer #(
    parameter int DEPTH = 64,
    parameter int B     = 12,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wr_ptr,
    input  logic [B-1:0]  wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_ptr,
    output logic [B-1:0]  rd_data
);

    logic [B-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= wr_data;
    end

    // Returning 0 when no read is requested keeps data_out quiet outside the burst.
    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else       rd_data <= re ? mem[rd_ptr] : '0;
    end

endmodule

// File: rtl/mvm_load_sequencer.sv
// mvm_load_sequencer: buffers a full matrix/vector from the host stream, then
// issues the core command pulse and a gap-free burst; for start, waits for
// core_done plus a drain period before taking the next command.
//   clk, reset                   : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op   : host command handshake (mvm_op_e encoding)
//   s_valid/s_ready/s_data       : host word stream, accepted only while filling
//   load_matrix/load_vector/start: registered one-cycle pulses to the core
//   data_out                     : registered burst word, 0 outside the burst
//   core_done                    : core completion pulse, honoured only while running
//   busy                         : high whenever not idle
module mvm_load_sequencer
    import mvm_pkg::*;
#(
    parameter int K     = MVM_K,
    parameter int B     = MVM_B,
    parameter int LEAD  = 1,
    parameter int DRAIN = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [B-1:0] s_data,
    output logic         load_matrix,
    output logic         load_vector,
    output logic         start,
    output logic [B-1:0] data_out,
    input  logic         core_done,
    output logic         busy
);

    localparam int N_MAT = K * K;
    localparam int AW    = N_MAT > 1 ? $clog2(N_MAT) : 1;
    localparam int CMAX  = (N_MAT > DRAIN ? N_MAT : DRAIN) + LEAD;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [AW-1:0] MAT_WLAST  = AW'(N_MAT - 1);
    localparam logic [AW-1:0] VEC_WLAST  = AW'(K - 1);
    localparam logic [CW-1:0] MAT_LAST   = CW'(N_MAT - 1);
    localparam logic [CW-1:0] VEC_LAST   = CW'(K - 1);
    localparam logic [CW-1:0] LEAD_LAST  = CW'(LEAD > 1 ? LEAD - 2 : 0);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN > 0 ? DRAIN - 1 : 0);

    seq_state_e    state;
    logic          is_mat;
    logic          is_load;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          wr_last;
    logic          burst_last;
    logic          lead_last;
    logic          re;
    logic          we;

    assign cmd_ready  = state == SEQ_IDLE && !reset;
    assign s_ready    = state == SEQ_FILL;
    assign busy       = state != SEQ_IDLE;
    assign we         = state == SEQ_FILL && s_valid;
    assign wr_last    = wr_ptr == (is_mat ? MAT_WLAST : VEC_WLAST);
    assign burst_last = cnt == (is_mat ? MAT_LAST : VEC_LAST);
    // Last cycle before the burst; the buffer read is issued here so that the
    // registered read data lands exactly LEAD cycles after the command pulse.
    assign lead_last  = LEAD == 1 ? state == SEQ_CMD && is_load
                                  : state == SEQ_LEADWAIT && cnt == LEAD_LAST;
    // rd_ptr runs one word ahead of data_out; no read in the final burst cycle.
    assign re         = lead_last || (state == SEQ_BURST && !burst_last);

    mvm_burst_buffer #(
        .DEPTH(N_MAT),
        .B    (B),
        .AW   (AW)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .wr_ptr (wr_ptr),
        .wr_data(s_data),
        .re     (re),
        .rd_ptr (rd_ptr),
        .rd_data(data_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEQ_IDLE;
            is_mat      <= 1'b0;
            is_load     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            load_matrix <= 1'b0;
            load_vector <= 1'b0;
            start       <= 1'b0;
        end else begin
            load_matrix <= 1'b0;
            load_vector <= 1'b0;
            start       <= 1'b0;
            if (re) rd_ptr <= rd_ptr + 1'b1;
            case (state)
                SEQ_IDLE: if (cmd_valid) begin
                    is_mat  <= cmd_op == MVM_OP_LOAD_MAT;
                    is_load <= cmd_op != MVM_OP_START;
                    wr_ptr  <= '0;
                    rd_ptr  <= '0;
                    start   <= cmd_op == MVM_OP_START;
                    state   <= (cmd_op == MVM_OP_LOAD_MAT || cmd_op == MVM_OP_LOAD_VEC) ? SEQ_FILL
                             : cmd_op == MVM_OP_START ? SEQ_CMD : SEQ_IDLE;
                end
                SEQ_FILL: if (s_valid) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (wr_last) begin
                        state       <= SEQ_CMD;
                        load_matrix <= is_mat;
                        load_vector <= !is_mat;
                    end
                end
                SEQ_CMD: begin
                    cnt   <= '0;
                    state <= !is_load ? SEQ_RUN : LEAD == 1 ? SEQ_BURST : SEQ_LEADWAIT;
                end
                SEQ_LEADWAIT: begin
                    cnt   <= lead_last ? '0 : cnt + 1'b1;
                    state <= lead_last ? SEQ_BURST : SEQ_LEADWAIT;
                end
                SEQ_BURST: begin
                    cnt   <= burst_last ? '0 : cnt + 1'b1;
                    state <= burst_last ? SEQ_IDLE : SEQ_BURST;
                end
                SEQ_RUN: if (core_done) begin
                    cnt   <= '0;
                    state <= SEQ_DRAIN;
                end
                SEQ_DRAIN: begin
                    cnt   <= cnt == DRAIN_LAST ? '0 : cnt + 1'b1;
                    state <= cnt == DRAIN_LAST ? SEQ_IDLE : SEQ_DRAIN;
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule
